// File: rtl/aes_host_ctrl_pkg.sv
// Shared types and constants for the UART-to-AES host controller.
//   state_t           : controller FSM states
//   CMD_KEY / CMD_ENC : host command bytes ('K' key load, 'E' encrypt)
//   RSP_ERR           : error response byte
//   BLK_W / BYTE_W    : AES block width and UART byte width
package aes_host_ctrl_pkg;

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = BLK_W / BYTE_W;

  localparam logic [BYTE_W-1:0] CMD_KEY = 8'h4B;
  localparam logic [BYTE_W-1:0] CMD_ENC = 8'h45;
  localparam logic [BYTE_W-1:0] RSP_ERR = 8'hEE;

  typedef enum logic [3:0] {
    IDLE,
    RX_KEY,
    RX_PT,
    KEY_REQ,
    KEY_WAIT,
    ENC_REQ,
    ENC_WAIT,
    TX_OUT,
    TX_ACK,
    TX_ERR
  } state_t;

endpackage

// File: rtl/aes_host_ctrl_if.sv
// Bundle of UART byte streams and AES core signals around the host controller.
//   master : the controller (drives TX byte stream and AES core controls)
//   slave  : the environment (UART RX/TX side and the AES core)
interface aes_host_ctrl_if;
  import aes_host_ctrl_pkg::*;

  // UART side
  logic [BYTE_W-1:0] RX_DATA;
  logic              RX_VLD;
  logic [BYTE_W-1:0] TX_DATA;
  logic              TX_VLD;
  logic              TX_RDY;

  // AES core side
  logic [BLK_W-1:0]  KIN_AES;
  logic [BLK_W-1:0]  DIN_AES;
  logic              KDRDY_AES;
  logic              EN_AES;
  logic              RSTn_AES;
  logic [BLK_W-1:0]  DOUT_AES;
  logic              DVLD_AES;
  logic              KVLD_AES;
  logic              BUSY_AES;

  // Status
  logic              BSY;

  modport master (
    input  RX_DATA, RX_VLD, TX_RDY, DOUT_AES, DVLD_AES, KVLD_AES, BUSY_AES,
    output TX_DATA, TX_VLD, KIN_AES, DIN_AES, KDRDY_AES, EN_AES, RSTn_AES, BSY
  );

  modport slave (
    output RX_DATA, RX_VLD, TX_RDY, DOUT_AES, DVLD_AES, KVLD_AES, BUSY_AES,
    input  TX_DATA, TX_VLD, KIN_AES, DIN_AES, KDRDY_AES, EN_AES, RSTn_AES, BSY
  );

endinterface

// File: rtl/aes_byte_shifter.sv
// 128-bit byte shifter: assembles received bytes and serializes the output block.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero the register
//   load       : parallel load of load_data
//   shift_in   : {data[119:0], byte_in}
//   shift_out  : rotate left by one byte so data[127:120] is the next byte to send
//   data       : register contents
module aes_byte_shifter
  import aes_host_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift_in,
  input  logic              shift_out,
  input  logic [BLK_W-1:0]  load_data,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [BLK_W-1:0]  data
);

  // Rotating on shift-out leaves the block intact after all 16 bytes are sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (clr) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_in) begin
      data <= {data[BLK_W-BYTE_W-1:0], byte_in};
    end else if (shift_out) begin
      data <= {data[BLK_W-BYTE_W-1:0], data[BLK_W-1 -: BYTE_W]};
    end
  end

endmodule

// File: rtl/aes_host_ctrl.sv
// UART command front-end for an AES core: loads keys, runs single-block
// encryptions and streams the ciphertext or a status byte back.
//   CLK, RST    : clock, synchronous active-high reset
//   bus.master  : UART RX/TX byte streams, AES core key/data/control, BSY
//   TIMEOUT_CYC : max cycles to wait for KVLD_AES / DVLD_AES
module aes_host_ctrl
  import aes_host_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic           CLK,
  input  logic           RST,
  aes_host_ctrl_if.master bus
);

  localparam int unsigned TO_W = (TIMEOUT_CYC >= 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t              state;
  logic [3:0]          byte_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                key_ok;
  logic [BLK_W-1:0]    key_q;
  logic [BLK_W-1:0]    pt_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic                tx_vld_q;
  logic                kdrdy_q;
  logic                en_q;
  logic                rstn_q;
  logic                bsy_q;

  logic [BLK_W-1:0]    sh_data;
  logic [BLK_W-1:0]    rx_next;
  logic                tx_fire;
  logic                last_byte;
  logic                cmd_hit;
  logic                sh_clr;
  logic                sh_load;
  logic                sh_shift_in;
  logic                sh_shift_out;

  // Shifter controls decoded from the current state and inputs
  assign tx_fire      = tx_vld_q & bus.TX_RDY;
  assign last_byte    = (byte_cnt == 4'(NBYTES - 1));
  assign rx_next      = {sh_data[BLK_W-BYTE_W-1:0], bus.RX_DATA};
  assign cmd_hit      = (bus.RX_DATA == CMD_KEY) || (bus.RX_DATA == CMD_ENC);
  assign sh_clr       = (state == IDLE) && bus.RX_VLD && cmd_hit;
  assign sh_shift_in  = bus.RX_VLD && ((state == RX_KEY) || (state == RX_PT));
  assign sh_load      = (state == ENC_WAIT) && bus.DVLD_AES;
  assign sh_shift_out = (state == TX_OUT) && tx_fire;

  aes_byte_shifter u_shifter (
    .clk       (CLK),
    .rst       (RST),
    .clr       (sh_clr),
    .load      (sh_load),
    .shift_in  (sh_shift_in),
    .shift_out (sh_shift_out),
    .load_data (bus.DOUT_AES),
    .byte_in   (bus.RX_DATA),
    .data      (sh_data)
  );

  // Core reset follows the block reset delayed by one cycle
  always_ff @(posedge CLK) begin
    rstn_q <= ~RST;
  end

  // Controller FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      key_ok    <= 1'b0;
      key_q     <= '0;
      pt_q      <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      kdrdy_q   <= 1'b0;
      en_q      <= 1'b0;
      bsy_q     <= 1'b0;
    end else begin
      kdrdy_q <= 1'b0;
      en_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.RX_VLD && cmd_hit) begin
            state    <= (bus.RX_DATA == CMD_KEY) ? RX_KEY : RX_PT;
            byte_cnt <= '0;
            bsy_q    <= 1'b1;
          end
        end
        RX_KEY: begin
          if (bus.RX_VLD) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (last_byte) begin
              key_q   <= rx_next;
              kdrdy_q <= 1'b1;
              state   <= KEY_REQ;
            end
          end
        end
        RX_PT: begin
          if (bus.RX_VLD) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (last_byte) begin
              if (key_ok) begin
                pt_q  <= rx_next;
                state <= ENC_REQ;
              end else begin
                tx_data_q <= RSP_ERR;
                tx_vld_q  <= 1'b1;
                state     <= TX_ERR;
              end
            end
          end
        end
        KEY_REQ: begin
          key_ok <= 1'b0;
          to_cnt <= '0;
          state  <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (bus.KVLD_AES) begin
            key_ok    <= 1'b1;
            tx_data_q <= CMD_KEY;
            tx_vld_q  <= 1'b1;
            state     <= TX_ACK;
          end else if (to_cnt == TO_LAST) begin
            tx_data_q <= RSP_ERR;
            tx_vld_q  <= 1'b1;
            state     <= TX_ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ENC_REQ: begin
          if (!bus.BUSY_AES) begin
            en_q   <= 1'b1;
            to_cnt <= '0;
            state  <= ENC_WAIT;
          end
        end
        ENC_WAIT: begin
          if (bus.DVLD_AES) begin
            tx_data_q <= bus.DOUT_AES[BLK_W-1 -: BYTE_W];
            tx_vld_q  <= 1'b1;
            byte_cnt  <= '0;
            state     <= TX_OUT;
          end else if (to_cnt == TO_LAST) begin
            tx_data_q <= RSP_ERR;
            tx_vld_q  <= 1'b1;
            state     <= TX_ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        TX_OUT: begin
          if (tx_fire) begin
            if (last_byte) begin
              tx_vld_q <= 1'b0;
              bsy_q    <= 1'b0;
              state    <= IDLE;
            end else begin
              // Byte below the top becomes the top after this rotate
              tx_data_q <= sh_data[BLK_W-BYTE_W-1 -: BYTE_W];
              byte_cnt  <= byte_cnt + 4'd1;
            end
          end
        end
        TX_ACK, TX_ERR: begin
          if (tx_fire) begin
            tx_vld_q <= 1'b0;
            bsy_q    <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx_vld_q <= 1'b0;
          bsy_q    <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX_DATA   = tx_data_q;
  assign bus.TX_VLD    = tx_vld_q;
  assign bus.KIN_AES   = key_q;
  assign bus.DIN_AES   = pt_q;
  assign bus.KDRDY_AES = kdrdy_q;
  assign bus.EN_AES    = en_q;
  assign bus.RSTn_AES  = rstn_q;
  assign bus.BSY       = bsy_q;

endmodule

// File: doc/aes_host_ctrl.md
AES_HOST_CTRL -- requirements
Module: aes_host_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 4096, giving the maximum cycles to wait for KVLD_AES or DVLD_AES.
REQ-002 CLK  in  1  single system clock; all logic rising-edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 RX_DATA  in  8  received UART byte.
REQ-005 RX_VLD  in  1  one-cycle strobe qualifying RX_DATA.
REQ-006 TX_DATA  out  8  byte to UART transmitter.
REQ-007 TX_VLD  out  1  TX_DATA valid; held until accepted.
REQ-008 TX_RDY  in  1  UART transmitter can accept a byte.
REQ-009 KIN_AES  out  128  key to AES core.
REQ-010 DIN_AES  out  128  plaintext to AES core.
REQ-011 KDRDY_AES  out  1  one-cycle key-load request pulse.
REQ-012 EN_AES  out  1  one-cycle encrypt-start pulse.
REQ-013 RSTn_AES  out  1  active-low core reset; registered ~RST.
REQ-014 DOUT_AES  in  128  ciphertext from core.
REQ-015 DVLD_AES  in  1  ciphertext valid strobe.
REQ-016 KVLD_AES  in  1  key-expansion done strobe.
REQ-017 BUSY_AES  in  1  core busy.
REQ-018 BSY  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be: IDLE, RX_KEY, RX_PT, KEY_REQ, KEY_WAIT, ENC_REQ, ENC_WAIT, TX_OUT, TX_ACK, TX_ERR.
REQ-020 In IDLE, an RX_VLD byte 0x4B ('K') SHALL go to RX_KEY, 0x45 ('E') to RX_PT; any other byte is dropped and the FSM stays in IDLE.
REQ-021 In RX_KEY/RX_PT, each RX_VLD byte SHALL shift into a 128-bit register as {reg[119:0], byte}, so the first byte lands in [127:120]; a 4-bit counter counts bytes 0..15.
REQ-022 On the 16th byte, RX_KEY SHALL go to KEY_REQ and RX_PT SHALL go to ENC_REQ. If no key is loaded (key_ok=0), RX_PT SHALL go to TX_ERR instead.
REQ-023 KEY_REQ SHALL drive KDRDY_AES=1 for exactly one cycle, clear key_ok, then go to KEY_WAIT.
REQ-024 KEY_WAIT: KVLD_AES=1 SHALL set key_ok and go to TX_ACK. If the timeout counter reaches TIMEOUT_CYC-1 first, the FSM SHALL go to TX_ERR.
REQ-025 ENC_REQ SHALL wait while BUSY_AES=1. It SHALL then pulse EN_AES for one cycle and go to ENC_WAIT.
REQ-026 ENC_WAIT: DVLD_AES=1 SHALL capture DOUT_AES into the output register and go to TX_OUT. The timeout behaves as in KEY_WAIT.
REQ-027 The timeout counter SHALL clear on entry to KEY_WAIT/ENC_WAIT. It increments each cycle in those states and does not saturate or wrap.
REQ-028 TX handshake: a byte transfers on the cycle where TX_VLD=1 and TX_RDY=1. TX_DATA SHALL stay stable while TX_VLD=1 and TX_RDY=0.
REQ-029 TX_OUT SHALL send 16 bytes MSB first ([127:120] first). After the 16th transfer it SHALL go to IDLE.
REQ-030 TX_ACK SHALL send one byte 0x4B and then go to IDLE. TX_ERR SHALL send one byte 0xEE and then go to IDLE.
REQ-031 RX_VLD bytes arriving in any state other than IDLE/RX_KEY/RX_PT SHALL be dropped without side effects.
REQ-032 If DVLD_AES/KVLD_AES assert in the same cycle as the FSM enters the WAIT state, the strobe SHALL be ignored. Only strobes seen while in the WAIT state count.
REQ-033 KIN_AES SHALL show the key register and DIN_AES the plaintext register at all times. Each SHALL be stable from its REQ pulse until the FSM returns to IDLE.

Reset
REQ-034 With RST=1 at a clock edge, the block SHALL set: state=IDLE, all counters=0, key_ok=0, KIN/DIN/output registers=0, TX_VLD=0, TX_DATA=0x00, KDRDY_AES=0, EN_AES=0, RSTn_AES=0, BSY=0.
REQ-035 RST asserted mid-operation (any state) SHALL abort with no further TX byte. RSTn_AES SHALL go high one cycle after RST deasserts.

Structure
REQ-036 The shared package SHALL hold: the state enum, command constants (CMD_KEY=0x4B, CMD_ENC=0x45, RSP_ERR=0xEE), and the block width 128.
REQ-037 One sub-module, aes_byte_shifter, SHALL implement the 128-bit load/shift-out register, reused for RX assembly and TX serialization.

Verification
REQ-038 Send 'K' then 00 01 ... 0F, with a bench core that returns KVLD 10 cycles after KDRDY -> KIN_AES=000102..0F, one KDRDY pulse, TX byte 0x4B.
REQ-039 After REQ-038, send 'E' then 00 11 22 ... FF, with the core returning DOUT=69C4E0D86A7B0430D8CDB78070B4C55A -> one EN pulse, TX bytes 69 C4 ... 5A in order.
REQ-040 Send 'E' plus 16 bytes after reset with no key loaded -> no EN pulse, single TX byte 0xEE.
REQ-041 Send a key load with KVLD never asserted -> 0xEE sent after TIMEOUT_CYC cycles; FSM returns to IDLE with BSY=0.
REQ-042 Hold TX_RDY low for 50 cycles mid-ciphertext, and assert BUSY_AES for 20 cycles before EN -> TX_DATA stable, no byte lost or duplicated, EN delayed until BUSY_AES=0.
REQ-043 Assert RST at byte 8 of TX_OUT -> TX_VLD=0 next cycle, no further bytes sent, key_ok=0.
